// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencing controller.
// Holds the data width, the controller state encoding and the PC-select codes
// used by the fetch-stage PC mux.
package pipe_pkg;

    localparam int unsigned DATA_W = 16;

    // PC mux select codes driven on pc_sel
    localparam logic [1:0] PcSelSeq = 2'b00;  // sequential fetch
    localparam logic [1:0] PcSelVec = 2'b01;  // interrupt vector
    localparam logic [1:0] PcSelWb  = 2'b10;  // PC popped by RTI, from WB

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StDrain   = 4'd1,
        StPushPc  = 4'd2,
        StPushCcr = 4'd3,
        StVector  = 4'd4,
        StPopCcr  = 4'd5,
        StPopPc   = 4'd6,
        StRtiWait = 4'd7,
        StResume  = 4'd8
    } state_e;

endpackage

// File: rtl/pipe_seq_ctrl.sv
// Interrupt entry / RTI sequencer for a 5-stage pipeline.
// Interrupt entry: drain in-flight work, push return PC then CCR, jump to INT_VEC.
// RTI: pop CCR then PC (LIFO), wait for the popped PC to reach WB, resume there.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   int_req, rti_id      interrupt request (level) and RTI decoded in ID
//   pc_if, ccr           return address and flags to save on interrupt
//   wb_pop_pc, wb_pc_data popped PC arriving in WB
//   push/pop/pop_pc/pop_ccr/int1/mem_wdata  stack micro-op controls to MEM
//   stall_if, flush_id   pipeline freeze / bubble insertion
//   pc_sel, new_pc       fetch PC redirect
//   int_ack, busy        acknowledge pulse, sequencer active
module pipe_seq_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned          DRAIN_CYCLES = 3,
    parameter logic [DATA_W-1:0]    INT_VEC      = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              int_req,
    input  logic              rti_id,
    input  logic [DATA_W-1:0] pc_if,
    input  logic [3:0]        ccr,
    input  logic              wb_pop_pc,
    input  logic [DATA_W-1:0] wb_pc_data,
    output logic              push,
    output logic              pop,
    output logic              pop_pc,
    output logic              pop_ccr,
    output logic              int1,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              stall_if,
    output logic              flush_id,
    output logic [1:0]        pc_sel,
    output logic [DATA_W-1:0] new_pc,
    output logic              int_ack,
    output logic              busy
);

    // Counter runs DRAIN_CYCLES-1 down to 0, giving DRAIN_CYCLES cycles in DRAIN
    localparam logic [2:0] CntInit = 3'(DRAIN_CYCLES - 1);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] ret_pc_q, ret_pc_d;
    logic [DATA_W-1:0] rti_pc_q, rti_pc_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ret_pc_d = ret_pc_q;
        rti_pc_d = rti_pc_q;
        unique case (state_q)
            StIdle: begin
                // RTI has priority; a held int_req is picked up on return to IDLE
                if (rti_id) begin
                    state_d = StPopCcr;
                end else if (int_req) begin
                    state_d  = StDrain;
                    ret_pc_d = pc_if;
                    cnt_d    = CntInit;
                end
            end
            StDrain: begin
                if (cnt_q == 3'd0) state_d = StPushPc;
                else               cnt_d   = cnt_q - 3'd1;
            end
            StPushPc:  state_d = StPushCcr;
            StPushCcr: state_d = StVector;
            StVector:  state_d = StIdle;
            StPopCcr:  state_d = StPopPc;
            StPopPc:   state_d = StRtiWait;
            StRtiWait: begin
                if (wb_pop_pc) begin
                    state_d  = StResume;
                    rti_pc_d = wb_pc_data;
                end
            end
            StResume:  state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 3'd0;
            ret_pc_q <= '0;
            rti_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ret_pc_q <= ret_pc_d;
            rti_pc_q <= rti_pc_d;
        end
    end

    // Moore decode from state_q; IDLE decodes to all-zero so reset clears outputs at once
    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        pop_pc    = 1'b0;
        pop_ccr   = 1'b0;
        int1      = 1'b0;
        mem_wdata = '0;
        stall_if  = 1'b0;
        flush_id  = 1'b0;
        pc_sel    = PcSelSeq;
        new_pc    = '0;
        int_ack   = 1'b0;
        unique case (state_q)
            StDrain, StRtiWait: begin
                stall_if = 1'b1;
                flush_id = 1'b1;
            end
            StPushPc: begin
                push      = 1'b1;
                int1      = 1'b1;
                mem_wdata = ret_pc_q;
                stall_if  = 1'b1;
                flush_id  = 1'b1;
            end
            StPushCcr: begin
                push      = 1'b1;
                int1      = 1'b1;
                mem_wdata = {12'b0, ccr};
                stall_if  = 1'b1;
                flush_id  = 1'b1;
            end
            StVector: begin
                pc_sel   = PcSelVec;
                new_pc   = INT_VEC;
                int_ack  = 1'b1;
                flush_id = 1'b1;
            end
            StPopCcr: begin
                pop      = 1'b1;
                pop_ccr  = 1'b1;
                stall_if = 1'b1;
                flush_id = 1'b1;
            end
            StPopPc: begin
                pop      = 1'b1;
                pop_pc   = 1'b1;
                stall_if = 1'b1;
                flush_id = 1'b1;
            end
            StResume: begin
                pc_sel   = PcSelWb;
                new_pc   = rti_pc_q;
                flush_id = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
module tb_pipe_seq_ctrl;

    // Control vector layout:
    // [10]push [9]pop [8]pop_pc [7]pop_ccr [6]int1 [5]stall_if [4]flush_id
    // [3:2]pc_sel [1]int_ack [0]busy
    localparam logic [10:0] CIdle   = 11'h000;
    localparam logic [10:0] CDrain  = 11'h031;
    localparam logic [10:0] CPush   = 11'h471;
    localparam logic [10:0] CVector = 11'h017;
    localparam logic [10:0] CPopCcr = 11'h2B1;
    localparam logic [10:0] CPopPc  = 11'h331;
    localparam logic [10:0] CWait   = 11'h031;
    localparam logic [10:0] CResume = 11'h019;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        int_req = 1'b0, int_req_b = 1'b0;
    logic        rti_id = 1'b0;
    logic        zero_b = 1'b0;
    logic [15:0] pc_if = 16'h0;
    logic [3:0]  ccr = 4'h0;
    logic        wb_pop_pc = 1'b0;
    logic [15:0] wb_pc_data = 16'h0;

    logic        push_a, pop_a, pop_pc_a, pop_ccr_a, int1_a, stall_a, flush_a, ack_a, busy_a;
    logic [1:0]  sel_a;
    logic [15:0] wdata_a, npc_a;
    logic        push_b, pop_b, pop_pc_b, pop_ccr_b, int1_b, stall_b, flush_b, ack_b, busy_b;
    logic [1:0]  sel_b;
    logic [15:0] wdata_b, npc_b;
    logic [10:0] ctl_a, ctl_b;

    int checks = 0;
    int failures = 0;

    assign ctl_a = {push_a, pop_a, pop_pc_a, pop_ccr_a, int1_a, stall_a, flush_a, sel_a, ack_a,
                    busy_a};
    assign ctl_b = {push_b, pop_b, pop_pc_b, pop_ccr_b, int1_b, stall_b, flush_b, sel_b, ack_b,
                    busy_b};

    always #5 clk = ~clk;

    pipe_seq_ctrl #(.DRAIN_CYCLES(3), .INT_VEC(16'h0000)) dut_a (
        .clk(clk), .rst_n(rst_n), .int_req(int_req), .rti_id(rti_id), .pc_if(pc_if),
        .ccr(ccr), .wb_pop_pc(wb_pop_pc), .wb_pc_data(wb_pc_data), .push(push_a),
        .pop(pop_a), .pop_pc(pop_pc_a), .pop_ccr(pop_ccr_a), .int1(int1_a),
        .mem_wdata(wdata_a), .stall_if(stall_a), .flush_id(flush_a), .pc_sel(sel_a),
        .new_pc(npc_a), .int_ack(ack_a), .busy(busy_a)
    );

    pipe_seq_ctrl #(.DRAIN_CYCLES(1), .INT_VEC(16'h0100)) dut_b (
        .clk(clk), .rst_n(rst_n), .int_req(int_req_b), .rti_id(zero_b), .pc_if(pc_if),
        .ccr(ccr), .wb_pop_pc(zero_b), .wb_pc_data(wb_pc_data), .push(push_b),
        .pop(pop_b), .pop_pc(pop_pc_b), .pop_ccr(pop_ccr_b), .int1(int1_b),
        .mem_wdata(wdata_b), .stall_if(stall_b), .flush_id(flush_b), .pc_sel(sel_b),
        .new_pc(npc_b), .int_ack(ack_b), .busy(busy_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_ctl_a", {5'b0, ctl_a}, {5'b0, CIdle});
        chk("rst_wdata_a", wdata_a, 16'h0000);
        chk("rst_npc_a", npc_a, 16'h0000);
        chk("rst_ctl_b", {5'b0, ctl_b}, {5'b0, CIdle});
        step();
        rst_n = 1'b1;
        step();
        chk("idle_ctl", {5'b0, ctl_a}, {5'b0, CIdle});

        // Interrupt entry, DRAIN_CYCLES=3 (cycle 0 = IDLE sample)
        pc_if = 16'h0040; ccr = 4'b1010; int_req = 1'b1;
        step();
        chk("int_c1_drain", {5'b0, ctl_a}, {5'b0, CDrain});
        pc_if = 16'h0099;
        step();
        chk("int_c2_drain", {5'b0, ctl_a}, {5'b0, CDrain});
        rti_id = 1'b1;  // must be ignored outside IDLE
        step();
        chk("int_c3_drain", {5'b0, ctl_a}, {5'b0, CDrain});
        rti_id = 1'b0;
        step();
        chk("int_c4_pushpc", {5'b0, ctl_a}, {5'b0, CPush});
        chk("int_c4_wdata", wdata_a, 16'h0040);
        step();
        chk("int_c5_pushccr", {5'b0, ctl_a}, {5'b0, CPush});
        chk("int_c5_wdata", wdata_a, 16'h000A);
        step();
        chk("int_c6_vector", {5'b0, ctl_a}, {5'b0, CVector});
        chk("int_c6_newpc", npc_a, 16'h0000);
        int_req = 1'b0;
        step();
        chk("int_back_idle", {5'b0, ctl_a}, {5'b0, CIdle});

        // RTI
        rti_id = 1'b1;
        wb_pc_data = 16'h0777;
        step();
        chk("rti_popccr", {5'b0, ctl_a}, {5'b0, CPopCcr});
        rti_id = 1'b0;
        step();
        chk("rti_poppc", {5'b0, ctl_a}, {5'b0, CPopPc});
        step();
        chk("rti_wait1", {5'b0, ctl_a}, {5'b0, CWait});
        step();
        chk("rti_wait2", {5'b0, ctl_a}, {5'b0, CWait});
        wb_pop_pc = 1'b1; wb_pc_data = 16'h0041;
        step();
        chk("rti_resume", {5'b0, ctl_a}, {5'b0, CResume});
        chk("rti_newpc", npc_a, 16'h0041);
        wb_pop_pc = 1'b0; wb_pc_data = 16'hFFFF;
        #1;
        chk("rti_newpc_latched", npc_a, 16'h0041);
        step();
        chk("rti_idle", {5'b0, ctl_a}, {5'b0, CIdle});

        // RTI and interrupt together: RTI first, then DRAIN
        rti_id = 1'b1; int_req = 1'b1; pc_if = 16'h0123; ccr = 4'h3;
        step();
        chk("both_popccr", {5'b0, ctl_a}, {5'b0, CPopCcr});
        rti_id = 1'b0;
        step();
        chk("both_poppc", {5'b0, ctl_a}, {5'b0, CPopPc});
        step();
        chk("both_wait", {5'b0, ctl_a}, {5'b0, CWait});
        wb_pop_pc = 1'b1; wb_pc_data = 16'h0200;
        step();
        chk("both_resume_pc", npc_a, 16'h0200);
        wb_pop_pc = 1'b0;
        step();
        chk("both_idle", {5'b0, ctl_a}, {5'b0, CIdle});
        step();
        chk("both_drain", {5'b0, ctl_a}, {5'b0, CDrain});
        step();
        step();
        step();
        chk("both_pushpc_wdata", wdata_a, 16'h0123);
        step();
        chk("both_pushccr_wdata", wdata_a, 16'h0003);
        step();
        chk("both_vector", {5'b0, ctl_a}, {5'b0, CVector});
        int_req = 1'b0;
        step();

        // Reset in DRAIN with cnt=1
        int_req = 1'b1; pc_if = 16'h0055;
        step();
        chk("rstmid_drain_c1", {5'b0, ctl_a}, {5'b0, CDrain});
        step();
        chk("rstmid_drain_c2", {5'b0, ctl_a}, {5'b0, CDrain});
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_ctl", {5'b0, ctl_a}, {5'b0, CIdle});
        chk("rstmid_wdata", wdata_a, 16'h0000);
        int_req = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rstmid_after", {5'b0, ctl_a}, {5'b0, CIdle});
        end

        // DRAIN_CYCLES=1 instance
        pc_if = 16'h0300; ccr = 4'h5; int_req_b = 1'b1;
        step();
        chk("d1_c1_drain", {5'b0, ctl_b}, {5'b0, CDrain});
        step();
        chk("d1_c2_pushpc", {5'b0, ctl_b}, {5'b0, CPush});
        chk("d1_c2_wdata", wdata_b, 16'h0300);
        step();
        chk("d1_c3_pushccr", {5'b0, ctl_b}, {5'b0, CPush});
        chk("d1_c3_wdata", wdata_b, 16'h0005);
        step();
        chk("d1_c4_vector", {5'b0, ctl_b}, {5'b0, CVector});
        chk("d1_c4_newpc", npc_b, 16'h0100);
        int_req_b = 1'b0;
        step();
        chk("d1_idle", {5'b0, ctl_b}, {5'b0, CIdle});
        chk("d1_a_quiet", {5'b0, ctl_a}, {5'b0, CIdle});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
